pipe_ctrl: RTL and testbench
============================

// Module: pipe_ctrl
// PURPOSE
//  Central stall/flush sequencer for the 5-stage MIPS pipeline. Merges per-stage stall
//  requests into the CTRL_WIDTH stall vector consumed by pc_reg/if_id/id_ex/ex_mem/mem_wb.
//  Defers exceptions that arrive while MEM is stalled, then issues a one-cycle flush
//  with the redirect PC. Watchdogs runaway stalls.
// PARAMETERS
//  CTRL_WIDTH     6   stall vector width: [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB
//  PC_WIDTH       32  width of exception vector / redirect PC
//  STALL_TIMEOUT  64  consecutive stalled cycles before stall_timeout is raised (>=2)
// PORTS
//  clk            in   1           system clock, rising edge
//  rst            in   1           synchronous, active-high reset
//  stallreq_if    in   1           IF stage needs hold (icache miss)
//  stallreq_id    in   1           ID needs hold (load-use hazard)
//  stallreq_ex    in   1           EX needs hold (multi-cycle mult/div)
//  stallreq_mem   in   1           MEM needs hold (dcache/bus wait)
//  exc_req        in   1           exception detected in MEM, one-cycle pulse
//  exc_vector     in   PC_WIDTH    handler address, valid with exc_req
//  stall          out  CTRL_WIDTH  per-stage hold vector (combinational)
//  flush          out  1           squash all stage registers this cycle
//  new_pc         out  PC_WIDTH    redirect PC, valid when flush=1, else 0
//  stall_timeout  out  1           sticky: stall exceeded STALL_TIMEOUT
// BEHAVIOUR
//  - Stall vector, highest requesting stage wins, zero latency (comb. from inputs + state):
//    mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000011, none 6'b000000.
//  - Downstream stage k+1 is never held when stage k is held by a lower request; the
//    if_id/id_ex registers insert a bubble on stall[k]=1 & stall[k+1]=0.
//  - FSM states: RUN, EXC_PEND.
//    RUN: exc_req & !stallreq_mem -> flush=1, new_pc=exc_vector, stall=0 (flush beats every
//      stall request), stay RUN. exc_req & stallreq_mem -> latch exc_vector into pend_pc,
//      go EXC_PEND, stall=6'b011111 this cycle.
//    EXC_PEND: stall from requests as normal; exc_req ignored (older exception owns MEM).
//      When stallreq_mem=0 -> flush=1, new_pc=pend_pc, stall=0, go RUN same edge.
//  - flush is a single-cycle pulse; back-to-back exc_req in RUN gives back-to-back flushes,
//    each with its own exc_vector.
//  - Stall counter (clog2(STALL_TIMEOUT)+1 bits): +1 each cycle stall!=0, cleared on any
//    stall==0 cycle (incl. flush cycles); saturates. Reaching STALL_TIMEOUT sets
//    stall_timeout, which holds until rst. Counter/timeout do not alter stall.
//  - Reset: state=RUN, pend_pc=0, counter=0, stall_timeout=0; stall/flush/new_pc are 0
//    while rst=1 regardless of inputs. Reset in EXC_PEND discards the pending exception.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cycles[31:0] and perf_flush_cnt[31:0];
//   first counts cycles with stall!=0, second counts flush pulses; both wrap at 2^32,
//   cleared by rst. Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 stallreq_id=1 for 3 cycles -> stall=6'b000111 exactly those 3 cycles, then 0; flush=0.
//  2 stallreq_if=1 & stallreq_ex=1 same cycle -> stall=6'b001111 (EX wins).
//  3 exc_req=1, exc_vector=0xBFC00380, no stalls -> same cycle flush=1, new_pc=0xBFC00380,
//    stall=0; next cycle flush=0, new_pc=0.
//  4 stallreq_mem=1 for 4 cycles, exc_req pulse (vec 0x80000180) in cycle 1, second
//    exc_req (vec 0x1234) in cycle 2 -> stall=6'b011111 cycles 1-4, flush=1 with
//    new_pc=0x80000180 in cycle 5, second exception never flushed.
//  5 STALL_TIMEOUT=8, stallreq_ex held 8 cycles -> stall_timeout rises after 8th stalled
//    cycle, stays 1 after request drops; 7-cycle stall in fresh run -> stays 0.
//  6 rst=1 during EXC_PEND -> all outputs 0; after release, stallreq_mem drop gives no flush.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: prioritised stall vector, deferred
// exceptions, sticky stall watchdog. Optional perf counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter int CTRL_WIDTH    = 6,
    parameter int PC_WIDTH      = 32,
    parameter int STALL_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stallreq_if,
    input  logic                  stallreq_id,
    input  logic                  stallreq_ex,
    input  logic                  stallreq_mem,
    input  logic                  exc_req,
    input  logic [PC_WIDTH-1:0]   exc_vector,
    output logic [CTRL_WIDTH-1:0] stall,
    output logic                  flush,
    output logic [PC_WIDTH-1:0]   new_pc,
    output logic                  stall_timeout
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_cnt
`endif
);

    localparam int CW = $clog2(STALL_TIMEOUT) + 1;

    localparam logic [CTRL_WIDTH-1:0] STALL_MEM = CTRL_WIDTH'(6'b011111);
    localparam logic [CTRL_WIDTH-1:0] STALL_EX  = CTRL_WIDTH'(6'b001111);
    localparam logic [CTRL_WIDTH-1:0] STALL_ID  = CTRL_WIDTH'(6'b000111);
    localparam logic [CTRL_WIDTH-1:0] STALL_IF  = CTRL_WIDTH'(6'b000011);

    typedef enum logic {
        RUN,
        EXC_PEND
    } state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   pend_pc_q, pend_pc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  timeout_q, timeout_d;
    logic [CTRL_WIDTH-1:0] req_stall;

    // Highest requesting stage wins; lower stages keep flowing so a bubble enters.
    always_comb begin
        if (stallreq_mem)     req_stall = STALL_MEM;
        else if (stallreq_ex) req_stall = STALL_EX;
        else if (stallreq_id) req_stall = STALL_ID;
        else if (stallreq_if) req_stall = STALL_IF;
        else                  req_stall = '0;
    end

    // NOTE: every output and next-state is given a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        stall     = req_stall;
        flush     = 1'b0;
        new_pc    = '0;

        if (rst) begin
            stall = '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (exc_req && !stallreq_mem) begin
                        flush  = 1'b1;
                        new_pc = exc_vector;
                        stall  = '0;
                    end else if (exc_req) begin
                        pend_pc_d = exc_vector;
                        state_d   = EXC_PEND;
                    end
                end
                EXC_PEND: begin
                    // Younger exceptions are dropped: the pending one still owns MEM.
                    if (!stallreq_mem) begin
                        flush   = 1'b1;
                        new_pc  = pend_pc_q;
                        stall   = '0;
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall == '0)          cnt_d = '0;
        else if (cnt_q != '1)     cnt_d = cnt_q + 1'b1;
        timeout_d = timeout_q | (cnt_d >= CW'(STALL_TIMEOUT));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            pend_pc_q <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            if (stall != '0) perf_stall_q <= perf_stall_q + 32'd1;
            if (flush)       perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_flush_cnt    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (STALL_TIMEOUT=8): stall priority,
// flush timing, deferred exceptions, watchdog and reset behaviour.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_req;
    logic [31:0] exc_vector;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(
        .CTRL_WIDTH   (6),
        .PC_WIDTH     (32),
        .STALL_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_req      (exc_req),
        .exc_vector   (exc_vector),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_timeout(stall_timeout)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flush_cnt   (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        exc_req      = 1'b0;
        exc_vector   = 32'h0;
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Sample the combinational outputs mid-cycle.
    task automatic expect_out(input string tag, input logic [5:0] e_stall,
                              input logic e_flush, input logic [31:0] e_pc);
        @(negedge clk);
        check({tag, ".stall"}, {26'h0, stall}, {26'h0, e_stall});
        check({tag, ".flush"}, {31'h0, flush}, {31'h0, e_flush});
        check({tag, ".new_pc"}, new_pc, e_pc);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        // Outputs forced quiet while reset is held, whatever the inputs.
        stallreq_mem = 1'b1; stallreq_id = 1'b1; exc_req = 1'b1; exc_vector = 32'hCAFE0000;
        expect_out("rst_hold", 6'b000000, 1'b0, 32'h0);
        cyc(); idle();
        check("rst_timeout", {31'h0, stall_timeout}, 32'h0);
        rst = 1'b0;
        expect_out("idle", 6'b000000, 1'b0, 32'h0);

        // 1: load-use hold for exactly three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(); stallreq_id = 1'b1;
            expect_out("t1_id", 6'b000111, 1'b0, 32'h0);
        end
        cyc(); idle();
        expect_out("t1_end", 6'b000000, 1'b0, 32'h0);

        // 2: priority
        cyc(); stallreq_if = 1'b1; stallreq_ex = 1'b1;
        expect_out("t2_ex_over_if", 6'b001111, 1'b0, 32'h0);
        cyc(); idle(); stallreq_if = 1'b1;
        expect_out("t2_if", 6'b000011, 1'b0, 32'h0);
        cyc(); idle(); stallreq_mem = 1'b1; stallreq_id = 1'b1;
        expect_out("t2_mem_over_id", 6'b011111, 1'b0, 32'h0);
        cyc(); idle();
        expect_out("t2_end", 6'b000000, 1'b0, 32'h0);

        // 3: immediate exception flush, then back-to-back flushes overriding stalls
        cyc(); exc_req = 1'b1; exc_vector = 32'hBFC00380;
        expect_out("t3_flush", 6'b000000, 1'b1, 32'hBFC00380);
        cyc(); idle();
        expect_out("t3_after", 6'b000000, 1'b0, 32'h0);
        cyc(); exc_req = 1'b1; exc_vector = 32'h11110000; stallreq_ex = 1'b1; stallreq_id = 1'b1;
        expect_out("t3_b2b_a", 6'b000000, 1'b1, 32'h11110000);
        cyc(); idle(); exc_req = 1'b1; exc_vector = 32'h22220000;
        expect_out("t3_b2b_b", 6'b000000, 1'b1, 32'h22220000);
        cyc(); idle();
        expect_out("t3_b2b_end", 6'b000000, 1'b0, 32'h0);

        // 4: exception deferred behind a MEM stall; the younger one is dropped
        cyc(); stallreq_mem = 1'b1; exc_req = 1'b1; exc_vector = 32'h80000180;
        expect_out("t4_c1", 6'b011111, 1'b0, 32'h0);
        cyc(); exc_req = 1'b1; exc_vector = 32'h00001234;
        expect_out("t4_c2", 6'b011111, 1'b0, 32'h0);
        cyc(); exc_req = 1'b0; exc_vector = 32'h0;
        expect_out("t4_c3", 6'b011111, 1'b0, 32'h0);
        cyc();
        expect_out("t4_c4", 6'b011111, 1'b0, 32'h0);
        cyc(); stallreq_mem = 1'b0;
        expect_out("t4_c5", 6'b000000, 1'b1, 32'h80000180);
        cyc();
        expect_out("t4_c6", 6'b000000, 1'b0, 32'h0);
        cyc();
        expect_out("t4_c7", 6'b000000, 1'b0, 32'h0);
        check("t4_timeout", {31'h0, stall_timeout}, 32'h0);

        // 5: watchdog, 7 cycles stays quiet, 8 cycles trips and sticks
        for (int i = 0; i < 7; i++) begin
            cyc(); stallreq_ex = 1'b1;
            expect_out("t5_run7", 6'b001111, 1'b0, 32'h0);
        end
        cyc(); idle();
        expect_out("t5_gap", 6'b000000, 1'b0, 32'h0);
        check("t5_no_timeout", {31'h0, stall_timeout}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            cyc(); stallreq_ex = 1'b1;
            expect_out("t5_run8", 6'b001111, 1'b0, 32'h0);
            check("t5_pre_timeout", {31'h0, stall_timeout}, 32'h0);
        end
        cyc(); idle();
        expect_out("t5_drop", 6'b000000, 1'b0, 32'h0);
        check("t5_timeout", {31'h0, stall_timeout}, 32'h1);
        cyc();
        check("t5_sticky", {31'h0, stall_timeout}, 32'h1);

        // 6: reset while an exception is pending discards it
        cyc(); stallreq_mem = 1'b1; exc_req = 1'b1; exc_vector = 32'hDEAD0000;
        expect_out("t6_pend", 6'b011111, 1'b0, 32'h0);
        cyc(); exc_req = 1'b0; exc_vector = 32'h0; stallreq_id = 1'b1; rst = 1'b1;
        expect_out("t6_rst", 6'b000000, 1'b0, 32'h0);
        cyc(); rst = 1'b0; idle(); stallreq_mem = 1'b1;
        expect_out("t6_post", 6'b011111, 1'b0, 32'h0);
        check("t6_timeout_clr", {31'h0, stall_timeout}, 32'h0);
        cyc(); stallreq_mem = 1'b0;
        expect_out("t6_no_flush", 6'b000000, 1'b0, 32'h0);
        cyc();
        expect_out("t6_quiet", 6'b000000, 1'b0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
